// File: rtl/stash_path_writeback_seq_if.sv
// Bundles the scan-table DMA read/return channels and the writeback command channel
// of the path writeback sequencer. master = sequencer side, slave = table/datapath side.
interface stash_path_writeback_seq_if #(
    parameter int ORAML     = 10,
    parameter int ORAMZ     = 5,
    parameter int SEA_WIDTH = 8
);
    localparam int BLOCKS = (ORAML + 1) * ORAMZ;
    localparam int STA_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int BKTA_W = (ORAML > 0) ? $clog2(ORAML + 1) : 1;

    logic [STA_W-1:0]     tbl_read_addr;
    logic                 tbl_read_valid;
    logic [SEA_WIDTH-1:0] tbl_data;
    logic                 tbl_data_valid;
    logic                 tbl_data_ready;
    logic [SEA_WIDTH-1:0] wb_saddr;
    logic                 wb_dummy;
    logic [BKTA_W-1:0]    wb_level;
    logic                 wb_valid;
    logic                 wb_ready;

    modport master (
        output tbl_read_addr, tbl_read_valid, tbl_data_ready,
        output wb_saddr, wb_dummy, wb_level, wb_valid,
        input  tbl_data, tbl_data_valid, wb_ready
    );

    modport slave (
        input  tbl_read_addr, tbl_read_valid, tbl_data_ready,
        input  wb_saddr, wb_dummy, wb_level, wb_valid,
        output tbl_data, tbl_data_valid, wb_ready
    );
endinterface

// File: rtl/stash_path_writeback_seq.sv
// Path writeback sequencer: walks every scan-table slot of the current path in address
// order with a credit limit on outstanding reads, and turns each returned stash address
// into a {saddr, dummy, level} writeback command through a one-entry output register.
module stash_path_writeback_seq #(
    parameter int ORAML     = 10,
    parameter int ORAMZ     = 5,
    parameter int SEA_WIDTH = 8,
    parameter int CREDITS   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic scan_table_ready,
    input  logic start,
    output logic busy,
    output logic done,
    output logic per_access_reset,
    stash_path_writeback_seq_if.master bus
);
    localparam int BLOCKS = (ORAML + 1) * ORAMZ;
    localparam int STA_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int BKTA_W = (ORAML > 0) ? $clog2(ORAML + 1) : 1;
    localparam int SLOT_W = (ORAMZ > 1) ? $clog2(ORAMZ) : 1;
    // Counters must be able to hold BLOCKS itself, one past the last table address.
    localparam int CNT_W  = $clog2(BLOCKS + 1);
    localparam int OUT_W  = $clog2(CREDITS + 1);

    localparam logic [SEA_WIDTH-1:0] SNULL      = {SEA_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]     LAST_SLOT  = CNT_W'(BLOCKS - 1);
    localparam logic [CNT_W-1:0]     ALL_SLOTS  = CNT_W'(BLOCKS);
    localparam logic [OUT_W-1:0]     CREDIT_MAX = OUT_W'(CREDITS);
    localparam logic [SLOT_W-1:0]    SLOT_LAST  = SLOT_W'(ORAMZ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     issue_cnt;
    logic [CNT_W-1:0]     ret_cnt;
    logic [OUT_W-1:0]     outstanding;
    logic [SLOT_W-1:0]    slot;
    logic [BKTA_W-1:0]    level;

    logic                 wb_valid_r;
    logic [SEA_WIDTH-1:0] wb_saddr_r;
    logic                 wb_dummy_r;
    logic [BKTA_W-1:0]    wb_level_r;

    logic issue;
    logic wb_free;
    logic accept;
    logic start_ok;

    // Handshake decode: read issue under credit, return accept into a free output register.
    always_comb begin
        issue    = (state == ISSUE) && (outstanding < CREDIT_MAX);
        wb_free  = ~wb_valid_r | bus.wb_ready;
        // Data arriving outside an access (e.g. after a mid-walk reset) is swallowed.
        accept   = bus.tbl_data_valid & wb_free & busy;
        start_ok = (state == IDLE) & start & scan_table_ready;
    end

    assign bus.tbl_read_valid = issue;
    assign bus.tbl_read_addr  = issue_cnt[STA_W-1:0];
    assign bus.tbl_data_ready = wb_free;
    assign bus.wb_valid       = wb_valid_r;
    assign bus.wb_saddr       = wb_saddr_r;
    assign bus.wb_dummy       = wb_dummy_r;
    assign bus.wb_level       = wb_level_r;

    // Access sequencing FSM with registered busy/done/per_access_reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            per_access_reset <= 1'b0;
        end else begin
            done             <= 1'b0;
            per_access_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Leave as the final read goes out, i.e. as issue_cnt reaches BLOCKS.
                    if (issue && (issue_cnt == LAST_SLOT)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((ret_cnt == ALL_SLOTS) && wb_free) begin
                        state            <= FIN;
                        done             <= 1'b1;
                        per_access_reset <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Walk counters: issue address, returns, credits in flight, and slot/level position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            slot        <= '0;
            level       <= '0;
        end else if (start_ok) begin
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            slot        <= '0;
            level       <= '0;
        end else begin
            if (issue) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (issue && !accept) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!issue && accept) begin
                outstanding <= outstanding - OUT_W'(1);
            end
            if (accept) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
                // Slot-within-bucket wraps into the next level; avoids a divide by ORAMZ.
                if (slot == SLOT_LAST) begin
                    slot  <= '0;
                    level <= level + BKTA_W'(1);
                end else begin
                    slot <= slot + SLOT_W'(1);
                end
            end
        end
    end

    // One-entry command register: loads on accept, empties when downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_r <= 1'b0;
            wb_saddr_r <= '0;
            wb_dummy_r <= 1'b0;
            wb_level_r <= '0;
        end else if (accept) begin
            wb_valid_r <= 1'b1;
            wb_saddr_r <= bus.tbl_data;
            wb_dummy_r <= (bus.tbl_data == SNULL);
            wb_level_r <= level;
        end else if (bus.wb_ready) begin
            wb_valid_r <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only sanity checks on the surrounding table's behaviour.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.tbl_data_valid && !busy) begin
                $error("stash_path_writeback_seq: table data returned while not busy");
                $finish;
            end
            if (issue && !accept && (outstanding == CREDIT_MAX)) begin
                $error("stash_path_writeback_seq: outstanding read count overflow");
                $finish;
            end
            if (accept && (ret_cnt == ALL_SLOTS)) begin
                $error("stash_path_writeback_seq: more returns than slots on path");
                $finish;
            end
        end
    end
`endif
endmodule

// File: tb/tb_stash_path_writeback_seq.sv
// Bench for stash_path_writeback_seq: a latency-programmable scan-table model feeds
// the sequencer; a monitor records commands and per-cycle properties; directed steps
// compare against a command list derived straight from the table contents.
module tb_stash_path_writeback_seq;
    localparam int ORAML     = 3;
    localparam int ORAMZ     = 2;
    localparam int SEA_WIDTH = 8;
    localparam int CREDITS   = 4;
    localparam int BLOCKS    = (ORAML + 1) * ORAMZ;
    localparam logic [7:0] SNULL = 8'hFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scan_table_ready = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
    logic per_access_reset;

    stash_path_writeback_seq_if #(.ORAML(ORAML), .ORAMZ(ORAMZ), .SEA_WIDTH(SEA_WIDTH)) bus ();

    stash_path_writeback_seq #(
        .ORAML(ORAML), .ORAMZ(ORAMZ), .SEA_WIDTH(SEA_WIDTH), .CREDITS(CREDITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scan_table_ready(scan_table_ready),
        .start(start),
        .busy(busy),
        .done(done),
        .per_access_reset(per_access_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] addr;
        int         t;
    } rd_t;

    int tests = 0;
    int fails = 0;
    logic [7:0] mem [BLOCKS];
    int lat = 1;
    int cyc = 0;
    int tcyc = 0;
    rd_t pend [$];
    logic [10:0] got_q [$];
    int last_acc_cyc = 0;
    int rd_walk = 0;
    int rd_total = 0;
    int out_model = 0;
    int max_out = 0;
    bit hold_prev = 0;
    logic [10:0] held = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scan table model: each read returns mem[addr] 'lat' cycles later, in order.
    initial begin
        bus.tbl_data_valid = 1'b0;
        bus.tbl_data = '0;
        forever begin
            @(posedge clk);
            tcyc++;
            if (rst) begin
                pend.delete();
            end else begin
                if (bus.tbl_data_valid && bus.tbl_data_ready) void'(pend.pop_front());
                if (bus.tbl_read_valid) pend.push_back('{addr: bus.tbl_read_addr, t: tcyc + lat - 1});
            end
            #1;
            if (pend.size() > 0 && pend[0].t <= tcyc) begin
                bus.tbl_data_valid = 1'b1;
                bus.tbl_data = mem[pend[0].addr];
            end else begin
                bus.tbl_data_valid = 1'b0;
                bus.tbl_data = '0;
            end
        end
    end

    // Monitor: credit limit, read order, hold-under-stall, command capture.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            out_model = 0;
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", bus.wb_valid, 1);
                chk("hold_cmd", {bus.wb_saddr, bus.wb_dummy, bus.wb_level}, held);
            end
            hold_prev = bus.wb_valid && !bus.wb_ready;
            held = {bus.wb_saddr, bus.wb_dummy, bus.wb_level};
            if (hold_prev) chk("stall_tbl_ready", bus.tbl_data_ready, 0);
            if (bus.tbl_read_valid) begin
                chk("credit_limit", out_model < CREDITS, 1);
                chk("read_addr", bus.tbl_read_addr, rd_walk % BLOCKS);
                rd_walk++;
                rd_total++;
            end
            out_model += int'(bus.tbl_read_valid) - int'(bus.tbl_data_valid && bus.tbl_data_ready);
            if (out_model > max_out) max_out = out_model;
            if (bus.wb_valid && bus.wb_ready) begin
                got_q.push_back({bus.wb_saddr, bus.wb_dummy, bus.wb_level});
                last_acc_cyc = cyc;
            end
        end
    end

    function automatic logic [10:0] expect_cmd(input int i);
        logic [1:0] lvl;
        lvl = 2'(i / ORAMZ);
        return {mem[i], (mem[i] == SNULL), lvl};
    endfunction

    task automatic randomize_table();
        for (int i = 0; i < BLOCKS; i++)
            mem[i] = ($urandom_range(0, 1) == 1) ? SNULL : 8'($urandom_range(0, 254));
    endtask

    // One full access: mode 0 = ready always, 1 = random ready, 2 = 10-cycle stall after 3 commands.
    task automatic run_walk(input string tag, input int latency, input int mode, input bit poke_start);
        int cycles = 0;
        int seen_par = 0;
        int stall_left = 0;
        bit stalled = 0;
        lat = latency;
        max_out = 0;
        @(negedge clk);
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_par"}, per_access_reset, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        got_q.delete();
        rd_walk = 0;
        bus.wb_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_first_read"}, bus.tbl_read_valid, 1);
        while (!done && cycles < 300) begin
            if (per_access_reset) seen_par++;
            case (mode)
                0: bus.wb_ready = 1'b1;
                1: bus.wb_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!stalled && got_q.size() >= 3) begin
                        stalled = 1;
                        stall_left = 10;
                    end
                    bus.wb_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
            endcase
            if (poke_start) start = (cycles == 3);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        chk({tag, "_done_reached"}, done, 1);
        chk({tag, "_par_with_done"}, per_access_reset, 1);
        chk({tag, "_par_early"}, seen_par, 0);
        chk({tag, "_busy_at_done"}, busy, 1);
        chk({tag, "_done_after_accept"}, cyc - last_acc_cyc, 0);
        chk({tag, "_cmd_count"}, got_q.size(), BLOCKS);
        chk({tag, "_read_count"}, rd_walk, BLOCKS);
        for (int i = 0; i < BLOCKS; i++)
            if (i < got_q.size()) chk({tag, "_cmd"}, got_q[i], expect_cmd(i));
        if (mode == 2) chk({tag, "_stall_applied"}, stalled, 1);
    endtask

    initial begin
        logic [7:0]  dpat;
        logic [15:0] lpat;
        int rd_before;
        int waited;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < BLOCKS; i++) mem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_par", per_access_reset, 0);
        chk("rst_read_valid", bus.tbl_read_valid, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_saddr", bus.wb_saddr, 0);
        chk("rst_wb_dummy", bus.wb_dummy, 0);
        chk("rst_wb_level", bus.wb_level, 0);
        rst = 1'b0;
        scan_table_ready = 1'b1;

        // Fixed table from the reference example
        mem[0] = 8'd3; mem[1] = SNULL; mem[2] = 8'd7; mem[3] = SNULL;
        mem[4] = SNULL; mem[5] = SNULL; mem[6] = 8'd1; mem[7] = SNULL;
        run_walk("basic", 1, 0, 0);
        dpat = '0;
        lpat = '0;
        for (int i = 0; i < BLOCKS; i++) begin
            if (i < got_q.size()) begin
                dpat[i] = got_q[i][2];
                lpat[2*i +: 2] = got_q[i][1:0];
            end
        end
        chk("basic_dummy_pattern", dpat, 8'hBA);
        chk("basic_level_pattern", lpat, 16'hFA50);

        // Slow table: credit limit must bind
        randomize_table();
        run_walk("credit", 6, 0, 0);
        chk("credit_max_outstanding", max_out, CREDITS);

        // Downstream stall mid-walk
        randomize_table();
        run_walk("wbstall", 2, 2, 0);

        // Random back-pressure plus a Start pulse while busy
        randomize_table();
        run_walk("randready", 3, 1, 1);

        // Start while the table is not ready is ignored
        scan_table_ready = 1'b0;
        rd_before = rd_total;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("notready_busy", busy, 0);
        chk("notready_reads", rd_total - rd_before, 0);
        scan_table_ready = 1'b1;

        // Reset in the middle of a walk
        randomize_table();
        lat = 2;
        @(negedge clk);
        got_q.delete();
        rd_walk = 0;
        bus.wb_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (got_q.size() < 3 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("midrst_three_cmds", got_q.size() >= 3, 1);
        rst = 1'b1;
        #1;
        chk("midrst_wb_valid", bus.wb_valid, 0);
        chk("midrst_wb_saddr", bus.wb_saddr, 0);
        chk("midrst_wb_dummy", bus.wb_dummy, 0);
        chk("midrst_wb_level", bus.wb_level, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_read_valid", bus.tbl_read_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_par", per_access_reset, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        randomize_table();
        run_walk("post_reset", 2, 0, 0);

        // Back-to-back accesses, second Start one cycle after Done
        randomize_table();
        run_walk("b2b_a", 1, 1, 0);
        randomize_table();
        run_walk("b2b_b", 1, 0, 0);
        @(negedge clk);
        chk("b2b_done_single", done, 0);
        chk("b2b_par_single", per_access_reset, 0);
        chk("b2b_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
